dac_update_sched: RTL and testbench
===================================

DAC_UPDATE_SCHED -- requirements
Module: dac_update_sched

Interface
REQ-001 Parameter UPDATE_PERIOD, default 8000, sets clk cycles between periodic update ticks (10 kHz at 80 MHz).
REQ-002 Parameter TRIG_LEN, default 4, sets the dac_trig high width in cycles; minimum 3.
REQ-003 Parameter BUSY_CYCLES, default 400, sets the blocking window after trig deassert, which covers one full 4-channel serializer pass.
REQ-004 clk  input  1  system clock, 80 MHz.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  high enables periodic ticks; force_update works regardless.
REQ-007 force_update  input  1  single-cycle request for an immediate update.
REQ-008 loop_wr_en / loop_wr_ch / loop_wr_data  input  1/2/16  control-loop shadow write request.
REQ-009 host_wr_en / host_wr_ch / host_wr_data  input  1/2/16  host shadow write request.
REQ-010 loop_wr_ack / host_wr_ack  output  1/1  single-cycle grant for the accepted write.
REQ-011 dac_data1..dac_data4  output  16 each  snapshot values presented to the DAC serializer.
REQ-012 dac_trig  output  1  update trigger to the serializer.
REQ-013 busy  output  1  high in LATCH, TRIG and BUSY states.
REQ-014 overrun  output  1  sticky flag: an update request arrived while one was already pending.
REQ-015 overrun_clr  input  1  clears overrun.
REQ-016 update_count  output  16  number of updates launched; wraps at 0xFFFF.

Function
REQ-017 The block SHALL hold four 16-bit shadow registers, indexed by wr_ch: 0 maps to ch1, 3 maps to ch4.
- Requests are level; a requester holds en and data until it sees ack.
- A write lands in the shadow register in the same cycle as its ack.
REQ-018 Write arbitration SHALL follow these rules:
- A single requester is granted immediately.
- On simultaneous requests, loop wins unless host lost the previous cycle; in that case host wins.
- At most one ack is issued per cycle.
REQ-019 The period counter SHALL count 0..UPDATE_PERIOD-1 while enable=1 and hold at 0 while enable=0.
- A tick occurs on wrap.
REQ-020 The pending flag SHALL set on a tick or on force_update, and clear on the IDLE->LATCH transition.
- If a tick or force_update occurs while pending is already 1, the block SHALL set overrun.
- If a set and overrun_clr coincide, set wins.
REQ-021 The state machine SHALL have states IDLE, LATCH, TRIG and BUSY, with these transitions:
- IDLE->LATCH when pending=1.
- LATCH->TRIG after 1 cycle.
- TRIG->BUSY after TRIG_LEN cycles.
- BUSY->IDLE after BUSY_CYCLES cycles.
REQ-022 In LATCH, dac_data1..4 SHALL load the shadow registers, including any write acked that same cycle.
- dac_data SHALL stay unchanged in every other state.
REQ-023 dac_trig SHALL be registered, high exactly TRIG_LEN cycles in TRIG and low otherwise.
REQ-024 update_count SHALL increment by 1 on entry to TRIG.
REQ-025 Shadow writes SHALL be accepted in every state.
- Writes made during TRIG or BUSY are applied at the next LATCH.
REQ-026 A request arriving during LATCH, TRIG or BUSY SHALL be held in pending and served on return to IDLE.
- The block SHALL not drop or queue more than one request.
REQ-027 Latency SHALL be exactly 2 cycles from force_update sampled in IDLE to dac_trig rising, when nothing is pending.

Reset
REQ-028 While reset is high, the block SHALL hold the following values:
- State IDLE.
- Shadow registers and dac_data1..4 at 0x0000.
- dac_trig, busy, overrun and both acks at 0.
- pending at 0, period counter at 0, update_count at 0.
REQ-029 A reset during TRIG SHALL drop dac_trig asynchronously and discard pending.
- After release, no trig occurs until a new request.

Verification
REQ-030 Check that the following scenarios pass.
- Single write: host writes ch2=0x1234, then force_update -> dac_trig high 4 cycles starting 2 cycles later, dac_data2=0x1234, others 0, update_count=1.
- Collision: loop and host request on the same cycles for 3 cycles -> acks go loop, host, loop; the shadow register holds the last granted data.
- Periodic: enable=1, UPDATE_PERIOD=100 -> trig rises every 100 cycles (BUSY_CYCLES+TRIG_LEN+1 < 100), with no overrun.
- Overrun: force_update pulsed twice during BUSY -> exactly one extra update after BUSY, overrun=1; overrun_clr -> overrun=0.
- Snapshot: write ch4=0xBEEF during BUSY -> dac_data4 unchanged until the next LATCH, then 0xBEEF.
- Reset mid-TRIG: reset asserted at TRIG cycle 2 -> dac_trig=0 immediately, state IDLE, all outputs at their reset values.

Source files
------------

// File: rtl/dac_update_sched.sv
// DAC update scheduler: arbitrates shadow writes from two requesters, snapshots them into
// the DAC data outputs and sequences trig/busy windows for the serializer.
module dac_update_sched #(
    parameter int UPDATE_PERIOD = 8000,
    parameter int TRIG_LEN      = 4,
    parameter int BUSY_CYCLES   = 400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        force_update,
    input  logic        loop_wr_en,
    input  logic [1:0]  loop_wr_ch,
    input  logic [15:0] loop_wr_data,
    input  logic        host_wr_en,
    input  logic [1:0]  host_wr_ch,
    input  logic [15:0] host_wr_data,
    output logic        loop_wr_ack,
    output logic        host_wr_ack,
    output logic [15:0] dac_data1,
    output logic [15:0] dac_data2,
    output logic [15:0] dac_data3,
    output logic [15:0] dac_data4,
    output logic        dac_trig,
    output logic        busy,
    output logic        overrun,
    input  logic        overrun_clr,
    output logic [15:0] update_count
);

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_TRIG, S_BUSY} state_t;

    localparam int CNT_MAX = (TRIG_LEN > BUSY_CYCLES) ? TRIG_LEN : BUSY_CYCLES;
    localparam int SW      = $clog2(CNT_MAX + 1);
    localparam int PW      = $clog2(UPDATE_PERIOD + 1);
    localparam logic [SW-1:0] TRIG_LAST   = SW'(TRIG_LEN - 1);
    localparam logic [SW-1:0] BUSY_LAST   = SW'(BUSY_CYCLES - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(UPDATE_PERIOD - 1);

    state_t             state, state_next;
    logic [SW-1:0]      state_cnt;
    logic [PW-1:0]      period_cnt;
    logic               tick, req, pending, host_lost;
    logic               loop_grant, host_grant, wr_en;
    logic [1:0]         wr_ch;
    logic [15:0]        wr_data;
    logic [3:0][15:0]   shadow, shadow_next, dac_data;
    logic               latch_en;

    // Loop has priority, except right after host lost a collision; acks are
    // combinational so the write lands at the end of the ack cycle.
    always_comb begin
        loop_grant  = loop_wr_en && !(host_wr_en && host_lost);
        host_grant  = host_wr_en && !loop_grant;
        loop_wr_ack = loop_grant && !reset;
        host_wr_ack = host_grant && !reset;
        wr_en       = loop_wr_ack || host_wr_ack;
        wr_ch       = loop_wr_ack ? loop_wr_ch : host_wr_ch;
        wr_data     = loop_wr_ack ? loop_wr_data : host_wr_data;
    end

    always_comb begin
        shadow_next = shadow;
        if (wr_en)
            shadow_next[wr_ch] = wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_lost <= 1'b0;
            shadow    <= '0;
        end else begin
            host_lost <= host_wr_en && loop_wr_ack;
            shadow    <= shadow_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            period_cnt <= '0;
        else if (!enable || period_cnt == PERIOD_LAST)
            period_cnt <= '0;
        else
            period_cnt <= period_cnt + 1'b1;
    end

    assign tick = enable && (period_cnt == PERIOD_LAST);
    assign req  = tick || force_update;

    // A new request wins over the clear so one arriving on the IDLE->LATCH edge is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (req)
                pending <= 1'b1;
            else if (state == S_IDLE && pending)
                pending <= 1'b0;
            if (req && pending)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (pending) state_next = S_LATCH;
            S_LATCH: state_next = S_TRIG;
            S_TRIG:  if (state_cnt == TRIG_LAST) state_next = S_BUSY;
            S_BUSY:  if (state_cnt == BUSY_LAST) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        latch_en = (state == S_LATCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_cnt <= '0;
        else if (state_next != state || !(state == S_TRIG || state == S_BUSY))
            state_cnt <= '0;
        else
            state_cnt <= state_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dac_trig     <= 1'b0;
            dac_data     <= '0;
            update_count <= '0;
        end else begin
            dac_trig <= (state_next == S_TRIG);
            if (latch_en) begin
                dac_data     <= shadow_next;
                update_count <= update_count + 16'd1;
            end
        end
    end

    assign dac_data1 = dac_data[0];
    assign dac_data2 = dac_data[1];
    assign dac_data3 = dac_data[2];
    assign dac_data4 = dac_data[3];

endmodule

// File: tb/tb_dac_update_sched.sv
// Directed bench for dac_update_sched: writes, arbitration, snapshot, overrun,
// periodic ticks and asynchronous reset during TRIG.
module tb_dac_update_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, force_update, overrun_clr;
    logic        loop_wr_en, host_wr_en;
    logic [1:0]  loop_wr_ch, host_wr_ch;
    logic [15:0] loop_wr_data, host_wr_data;
    logic        loop_wr_ack, host_wr_ack;
    logic [15:0] dac_data1, dac_data2, dac_data3, dac_data4;
    logic        dac_trig, busy, overrun;
    logic [15:0] update_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    dac_update_sched #(.UPDATE_PERIOD(100), .TRIG_LEN(4), .BUSY_CYCLES(20)) dut (
        .clk(clk), .reset(reset), .enable(enable), .force_update(force_update),
        .loop_wr_en(loop_wr_en), .loop_wr_ch(loop_wr_ch), .loop_wr_data(loop_wr_data),
        .host_wr_en(host_wr_en), .host_wr_ch(host_wr_ch), .host_wr_data(host_wr_data),
        .loop_wr_ack(loop_wr_ack), .host_wr_ack(host_wr_ack),
        .dac_data1(dac_data1), .dac_data2(dac_data2), .dac_data3(dac_data3), .dac_data4(dac_data4),
        .dac_trig(dac_trig), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr),
        .update_count(update_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (at negedges) for dac_trig high; records the cycle it was seen.
    task automatic wait_trig(input string tag, input int max, output int at);
        bit seen = 0;
        at = -1;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (dac_trig) begin
                seen = 1;
                at = cyc;
            end
        end
        check({tag, "_trig_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit idle = 0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        check({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    task automatic pulse_force();
        force_update = 1'b1;
        step();
        force_update = 1'b0;
    endtask

    initial begin
        int t0, t1, t2, hi, ntrig;
        reset = 1'b1; enable = 1'b0; force_update = 1'b0; overrun_clr = 1'b0;
        loop_wr_en = 1'b0; loop_wr_ch = 2'd0; loop_wr_data = 16'h0;
        host_wr_en = 1'b1; host_wr_ch = 2'd0; host_wr_data = 16'hDEAD;

        // Reset state, with a request held to show acks stay low
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_trig", 32'(dac_trig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", {30'd0, loop_wr_ack, host_wr_ack}, 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_data", {dac_data1, dac_data2}, 32'd0);
        check("rst_cnt", 32'(update_count), 32'd0);
        step();
        reset = 1'b0; host_wr_en = 1'b0;
        step();

        // Single write then forced update: trig 2 cycles after force, 4 wide
        host_wr_en = 1'b1; host_wr_ch = 2'd1; host_wr_data = 16'h1234;
        @(negedge clk);
        check("sw_host_ack", {30'd0, loop_wr_ack, host_wr_ack}, 32'd1);
        step();
        host_wr_en = 1'b0;
        pulse_force();
        @(negedge clk);
        check("sw_lat0", 32'(dac_trig), 32'd0);
        step();
        @(negedge clk);
        check("sw_lat1_trig", 32'(dac_trig), 32'd0);
        check("sw_lat1_busy", 32'(busy), 32'd1);
        step();
        @(negedge clk);
        check("sw_lat2_trig", 32'(dac_trig), 32'd1);
        check("sw_data2", 32'(dac_data2), 32'h1234);
        check("sw_data_other", {dac_data1, dac_data3}, 32'd0);
        check("sw_data4", 32'(dac_data4), 32'd0);
        check("sw_count", 32'(update_count), 32'd1);
        hi = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!dac_trig) break;
            hi++;
        end
        check("sw_trig_width", 32'(hi), 32'd4);
        check("sw_busy_after_trig", 32'(busy), 32'd1);
        wait_idle("sw");
        step();

        // Collision for 3 cycles: loop, host, loop
        loop_wr_en = 1'b1; loop_wr_ch = 2'd0; loop_wr_data = 16'h1111;
        host_wr_en = 1'b1; host_wr_ch = 2'd0; host_wr_data = 16'h2222;
        @(negedge clk);
        check("col_c1", {30'd0, loop_wr_ack, host_wr_ack}, 32'd2);
        step();
        loop_wr_data = 16'h3333; host_wr_data = 16'h4444;
        @(negedge clk);
        check("col_c2", {30'd0, loop_wr_ack, host_wr_ack}, 32'd1);
        step();
        loop_wr_data = 16'h5555; host_wr_data = 16'h6666;
        @(negedge clk);
        check("col_c3", {30'd0, loop_wr_ack, host_wr_ack}, 32'd2);
        step();
        loop_wr_en = 1'b0; host_wr_en = 1'b0;
        pulse_force();
        wait_trig("col", 10, t0);
        check("col_data1", 32'(dac_data1), 32'h5555);
        check("col_data2", 32'(dac_data2), 32'h1234);
        check("col_count", 32'(update_count), 32'd2);
        wait_idle("col");
        step();

        // Snapshot and overrun: write ch4 and force twice while in BUSY
        pulse_force();
        wait_trig("snap", 10, t0);
        for (int i = 0; i < 10 && dac_trig; i++) @(negedge clk);
        check("snap_in_busy", {30'd0, busy, dac_trig}, 32'd2);
        step();
        loop_wr_en = 1'b1; loop_wr_ch = 2'd3; loop_wr_data = 16'hBEEF;
        @(negedge clk);
        check("snap_ack", 32'(loop_wr_ack), 32'd1);
        step();
        loop_wr_en = 1'b0;
        pulse_force();
        step();
        pulse_force();
        @(negedge clk);
        check("snap_data4_held", 32'(dac_data4), 32'h0000);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_busy", 32'(busy), 32'd1);
        wait_trig("ovr_extra", 40, t0);
        check("snap_data4_new", 32'(dac_data4), 32'hBEEF);
        check("ovr_count", 32'(update_count), 32'd4);
        ntrig = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dac_trig) ntrig++;
        end
        check("ovr_one_extra", 32'(ntrig), 32'd3);
        check("ovr_sticky", 32'(overrun), 32'd1);
        step();
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        @(negedge clk);
        check("ovr_clr", 32'(overrun), 32'd0);
        check("ovr_cnt_stable", 32'(update_count), 32'd4);

        // Periodic ticks every 100 cycles
        step();
        enable = 1'b1;
        wait_trig("per1", 150, t0);
        for (int i = 0; i < 10 && dac_trig; i++) @(negedge clk);
        wait_trig("per2", 120, t1);
        for (int i = 0; i < 10 && dac_trig; i++) @(negedge clk);
        wait_trig("per3", 120, t2);
        check("per_int1", 32'(t1 - t0), 32'd100);
        check("per_int2", 32'(t2 - t1), 32'd100);
        check("per_ovr", 32'(overrun), 32'd0);
        check("per_count", 32'(update_count), 32'd7);
        step();
        enable = 1'b0;
        wait_idle("per");
        repeat (5) step();

        // Reset during TRIG cycle 2 with a request pending
        pulse_force();
        wait_trig("rmt", 10, t0);
        step();
        force_update = 1'b1;
        step();
        force_update = 1'b0;
        @(negedge clk);
        check("rmt_trig_c2", 32'(dac_trig), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rmt_trig_drop", 32'(dac_trig), 32'd0);
        check("rmt_busy", 32'(busy), 32'd0);
        check("rmt_count", 32'(update_count), 32'd0);
        check("rmt_data", {dac_data2, dac_data4}, 32'd0);
        check("rmt_data13", {dac_data1, dac_data3}, 32'd0);
        check("rmt_ovr", 32'(overrun), 32'd0);
        step();
        reset = 1'b0;
        ntrig = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dac_trig || busy) ntrig++;
        end
        check("rmt_no_trig", 32'(ntrig), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
